// File: rtl/u3v_leader_trailer_if.sv
// Leader/trailer word stream: 32-bit data plus framing flags, valid/ready handshake.
// The master holds every field stable while valid is high and ready is low.
interface u3v_leader_trailer_if;
  logic [31:0] ov_data;
  logic        o_data_valid;
  logic        i_data_ready;
  logic        o_leader;
  logic        o_trailer;
  logic        o_eop;

  modport master (
    output ov_data,
    output o_data_valid,
    output o_leader,
    output o_trailer,
    output o_eop,
    input  i_data_ready
  );

  modport slave (
    input  ov_data,
    input  o_data_valid,
    input  o_leader,
    input  o_trailer,
    input  o_eop,
    output i_data_ready
  );
endinterface

// File: rtl/u3v_leader_trailer.sv
// USB3 Vision leader (13 words) / trailer (8 words) generator. First leader word is valid 5 clk after
// i_fval rises; all outputs are registered, words stream at 1/clk and hold while valid & !ready.
module u3v_leader_trailer #(
  parameter int          LONG_REG_WD  = 64,
  parameter int          LEADER_SIZE  = 52,
  parameter int          TRAILER_SIZE = 32,
  parameter logic [15:0] PAYLOAD_TYPE = 16'h0001
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   i_fval,
  input  logic [LONG_REG_WD-1:0] iv_timestamp_u3,
  input  logic [31:0]            iv_pixel_format,
  input  logic [31:0]            iv_size_x,
  input  logic [31:0]            iv_size_y,
  input  logic [31:0]            iv_offset_x,
  input  logic [31:0]            iv_offset_y,
  input  logic [31:0]            iv_valid_payload_size,
  output logic                   o_frame_drop,
  u3v_leader_trailer_if.master   st
);

  localparam logic [31:0] LEADER_MAGIC  = 32'h4C56_3355;
  localparam logic [31:0] TRAILER_MAGIC = 32'h5456_3355;
  localparam logic [15:0] LDR_SZ        = 16'(LEADER_SIZE);
  localparam logic [15:0] TRL_SZ        = 16'(TRAILER_SIZE);
  localparam logic [15:0] STATUS_DROP   = 16'hA100;
  localparam logic [3:0]  LDR_LAST      = 4'd12;
  localparam logic [3:0]  TRL_LAST      = 4'd7;

  typedef enum logic [2:0] {
    S_IDLE,
    S_TS_WAIT,
    S_LEADER,
    S_WAIT_FALL,
    S_TRAILER
  } state_e;

  state_e                 state_q, state_d;
  logic [3:0]             idx_q, idx_d;
  logic                   tsw_q, tsw_d;
  logic [2:0]             fval_shift_q;
  logic [LONG_REG_WD-1:0] bid_q;
  logic [LONG_REG_WD-1:0] ts_q;
  logic [31:0]            pix_q, sx_q, sy_q, ox_q, oy_q, pay_q;
  logic                   fall_seen_q;
  logic                   skip_q;
  logic                   drop_flag_q;
  logic                   drop_q;

  logic [31:0]            dat_q, dat_d;
  logic                   vld_q, vld_d;
  logic                   ldr_q, ldr_d;
  logic                   trl_q, trl_d;
  logic                   eop_q, eop_d;

  logic                   rise, fall, fall_ok, drop_det;
  logic                   accept, out_load;
  logic                   capture, frame_done;
  logic [63:0]            bid64, ts64;
  logic [15:0]            status;

  assign rise     = (fval_shift_q[2:1] == 2'b01);
  assign fall     = (fval_shift_q[2:1] == 2'b10);
  // A fall belonging to a skipped frame must not end the frame being emitted.
  assign fall_ok  = fall && !skip_q && (state_q != S_IDLE);
  assign drop_det = rise && (state_q != S_IDLE);

  assign accept   = vld_q && st.i_data_ready;
  assign out_load = !(vld_q && !st.i_data_ready);

  assign bid64    = 64'(bid_q);
  assign ts64     = 64'(ts_q);
  assign status   = (drop_flag_q || drop_det) ? STATUS_DROP : 16'h0000;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    tsw_d      = tsw_q;
    capture    = 1'b0;
    frame_done = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (rise) begin
          state_d = S_TS_WAIT;
          tsw_d   = 1'b0;
        end
      end
      S_TS_WAIT: begin
        // Two cycles here give the timestamp block time to publish the frame-edge value.
        if (tsw_q) begin
          state_d = S_LEADER;
          idx_d   = 4'd0;
          capture = 1'b1;
        end else begin
          tsw_d = 1'b1;
        end
      end
      S_LEADER: begin
        if (accept) begin
          if (idx_q == LDR_LAST) begin
            idx_d   = 4'd0;
            state_d = (fall_seen_q || fall_ok) ? S_TRAILER : S_WAIT_FALL;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      S_WAIT_FALL: begin
        if (fall_ok) begin
          state_d = S_TRAILER;
          idx_d   = 4'd0;
        end
      end
      S_TRAILER: begin
        if (accept) begin
          if (idx_q == TRL_LAST) begin
            state_d    = S_IDLE;
            idx_d      = 4'd0;
            frame_done = 1'b1;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        idx_d   = 4'd0;
      end
    endcase
  end

  // Output register contents are derived from the next state/index so they line up with the FSM.
  always_comb begin
    dat_d = 32'h0;
    vld_d = (state_d == S_LEADER) || (state_d == S_TRAILER);
    ldr_d = (state_d == S_LEADER);
    trl_d = (state_d == S_TRAILER);
    eop_d = ((state_d == S_LEADER) && (idx_d == LDR_LAST)) ||
            ((state_d == S_TRAILER) && (idx_d == TRL_LAST));
    if (state_d == S_LEADER) begin
      case (idx_d)
        4'd0:    dat_d = LEADER_MAGIC;
        4'd1:    dat_d = {LDR_SZ, 16'h0000};
        4'd2:    dat_d = bid64[31:0];
        4'd3:    dat_d = bid64[63:32];
        4'd4:    dat_d = {PAYLOAD_TYPE, 16'h0000};
        4'd5:    dat_d = ts64[31:0];
        4'd6:    dat_d = ts64[63:32];
        4'd7:    dat_d = pix_q;
        4'd8:    dat_d = sx_q;
        4'd9:    dat_d = sy_q;
        4'd10:   dat_d = ox_q;
        4'd11:   dat_d = oy_q;
        default: dat_d = 32'h0;
      endcase
    end else if (state_d == S_TRAILER) begin
      case (idx_d)
        4'd0:    dat_d = TRAILER_MAGIC;
        4'd1:    dat_d = {TRL_SZ, 16'h0000};
        4'd2:    dat_d = bid64[31:0];
        4'd3:    dat_d = bid64[63:32];
        4'd4:    dat_d = {16'h0000, status};
        4'd5:    dat_d = pay_q;
        4'd6:    dat_d = 32'h0;
        4'd7:    dat_d = sy_q;
        default: dat_d = 32'h0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      idx_q        <= 4'd0;
      tsw_q        <= 1'b0;
      fval_shift_q <= 3'b000;
      bid_q        <= '0;
      ts_q         <= '0;
      pix_q        <= 32'h0;
      sx_q         <= 32'h0;
      sy_q         <= 32'h0;
      ox_q         <= 32'h0;
      oy_q         <= 32'h0;
      pay_q        <= 32'h0;
      fall_seen_q  <= 1'b0;
      skip_q       <= 1'b0;
      drop_flag_q  <= 1'b0;
      drop_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      tsw_q        <= tsw_d;
      fval_shift_q <= {fval_shift_q[1:0], i_fval};
      drop_q       <= drop_det;
      if (capture) begin
        ts_q  <= iv_timestamp_u3;
        pix_q <= iv_pixel_format;
        sx_q  <= iv_size_x;
        sy_q  <= iv_size_y;
        ox_q  <= iv_offset_x;
        oy_q  <= iv_offset_y;
      end
      if (fall_ok) begin
        pay_q <= iv_valid_payload_size;
      end
      if (state_d == S_IDLE) begin
        fall_seen_q <= 1'b0;
      end else if (fall_ok) begin
        fall_seen_q <= 1'b1;
      end
      // The dropped frame's fval is still high; its fall is the next fall seen.
      if (drop_det) begin
        skip_q <= 1'b1;
      end else if (fall) begin
        skip_q <= 1'b0;
      end
      if (frame_done) begin
        drop_flag_q <= 1'b0;
      end else if (drop_det) begin
        drop_flag_q <= 1'b1;
      end
      if (frame_done) begin
        bid_q <= bid_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dat_q <= 32'h0;
      vld_q <= 1'b0;
      ldr_q <= 1'b0;
      trl_q <= 1'b0;
      eop_q <= 1'b0;
    end else if (out_load) begin
      dat_q <= dat_d;
      vld_q <= vld_d;
      ldr_q <= ldr_d;
      trl_q <= trl_d;
      eop_q <= eop_d;
    end
  end

  assign st.ov_data      = dat_q;
  assign st.o_data_valid = vld_q;
  assign st.o_leader     = ldr_q;
  assign st.o_trailer    = trl_q;
  assign st.o_eop        = eop_q;
  assign o_frame_drop    = drop_q;

endmodule

// File: tb/tb_u3v_leader_trailer.sv
// Directed bench for u3v_leader_trailer: frame streams, backpressure, short fval, frame drop, mid-packet reset.
module tb_u3v_leader_trailer;
  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        i_fval = 1'b0;
  logic [63:0] ts_v = 64'h0000_0001_0000_00C8;
  logic [31:0] pix_v = 32'h0108_0001;
  logic [31:0] sx_v = 32'd640;
  logic [31:0] sy_v = 32'd480;
  logic [31:0] ox_v = 32'd16;
  logic [31:0] oy_v = 32'd8;
  logic [31:0] pay_in = 32'h0004_B000;
  logic        o_frame_drop;
  int          checks = 0;
  int          failures = 0;
  bit          rand_rdy = 1'b0;

  u3v_leader_trailer_if st_if ();

  u3v_leader_trailer dut (
    .clk                   (clk),
    .reset_n               (reset_n),
    .i_fval                (i_fval),
    .iv_timestamp_u3       (ts_v),
    .iv_pixel_format       (pix_v),
    .iv_size_x             (sx_v),
    .iv_size_y             (sy_v),
    .iv_offset_x           (ox_v),
    .iv_offset_y           (oy_v),
    .iv_valid_payload_size (pay_in),
    .o_frame_drop          (o_frame_drop),
    .st                    (st_if)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Waits for the next accepted word; checks that stalled words stay put.
  task automatic get_word(output logic [31:0] d, output logic [2:0] f, output int waits);
    bit          got;
    bit          stalled;
    logic [35:0] held;
    got   = 1'b0;
    waits = 0;
    d     = 32'h0;
    f     = 3'b000;
    while (!got && waits < 300) begin
      if (rand_rdy) st_if.i_data_ready = 1'($urandom_range(0, 1));
      stalled = 1'b0;
      if (st_if.o_data_valid && st_if.i_data_ready) begin
        d   = st_if.ov_data;
        f   = {st_if.o_leader, st_if.o_trailer, st_if.o_eop};
        got = 1'b1;
      end else if (st_if.o_data_valid) begin
        held    = {1'b1, st_if.o_leader, st_if.o_trailer, st_if.o_eop, st_if.ov_data};
        stalled = 1'b1;
      end
      step();
      if (stalled)
        chk("stall_hold", 64'({st_if.o_data_valid, st_if.o_leader, st_if.o_trailer,
                               st_if.o_eop, st_if.ov_data}), 64'(held));
      if (!got) waits++;
    end
    chk("word_timeout", 64'(got), 64'd1);
  endtask

  task automatic collect_leader(input logic [63:0] bid, input string tag, output int lat0);
    logic [31:0] exp_w [13];
    logic [31:0] d;
    logic [2:0]  f;
    int          w;
    exp_w = '{32'h4C56_3355, 32'h0034_0000, bid[31:0], bid[63:32], 32'h0001_0000,
              ts_v[31:0], ts_v[63:32], pix_v, sx_v, sy_v, ox_v, oy_v, 32'h0};
    lat0 = -1;
    for (int i = 0; i < 13; i++) begin
      get_word(d, f, w);
      if (i == 0) lat0 = w;
      chk($sformatf("%s_W%0d", tag, i), 64'(d), 64'(exp_w[i]));
      chk($sformatf("%s_W%0d_flags", tag, i), 64'(f), 64'({1'b1, 1'b0, (i == 12)}));
    end
  endtask

  task automatic collect_trailer(input logic [63:0] bid, input logic [15:0] status,
                                 input logic [31:0] pay, input string tag, output int lat0);
    logic [31:0] exp_w [8];
    logic [31:0] d;
    logic [2:0]  f;
    int          w;
    exp_w = '{32'h5456_3355, 32'h0020_0000, bid[31:0], bid[63:32], {16'h0, status},
              pay, 32'h0, sy_v};
    lat0 = -1;
    for (int i = 0; i < 8; i++) begin
      get_word(d, f, w);
      if (i == 0) lat0 = w;
      chk($sformatf("%s_T%0d", tag, i), 64'(d), 64'(exp_w[i]));
      chk($sformatf("%s_T%0d_flags", tag, i), 64'(f), 64'({1'b0, 1'b1, (i == 7)}));
    end
  endtask

  task automatic run_frame(input int hi, input logic [63:0] bid, input string tag, output int lat0);
    int lt;
    logic [31:0] pay;
    pay    = pay_in;
    i_fval = 1'b1;
    fork
      begin
        repeat (hi) step();
        i_fval = 1'b0;
      end
      begin
        collect_leader(bid, tag, lat0);
        collect_trailer(bid, 16'h0000, pay, tag, lt);
      end
    join
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_vld"}, 64'(st_if.o_data_valid), 64'd0);
    chk({tag, "_dat"}, 64'(st_if.ov_data), 64'd0);
    chk({tag, "_flags"}, 64'({st_if.o_leader, st_if.o_trailer, st_if.o_eop}), 64'd0);
    chk({tag, "_drop"}, 64'(o_frame_drop), 64'd0);
  endtask

  initial begin
    int lat;
    int lat_t;
    int cnt;
    logic [31:0] d;
    logic [2:0]  f;

    st_if.i_data_ready = 1'b1;
    #2 reset_n = 1'b0;
    repeat (3) step();
    chk_outputs_zero("reset");
    reset_n = 1'b1;
    step();
    chk_outputs_zero("idle");

    // Basic frame: 100-clk fval, timestamp 0x1_000000C8.
    run_frame(100, 64'd0, "A", lat);
    chk("A_first_word_latency", 64'(lat), 64'd5);

    // Back-to-back frames advance the block id after each trailer.
    run_frame(40, 64'd1, "B", lat);
    run_frame(40, 64'd2, "C", lat);

    // Random backpressure.
    rand_rdy = 1'b1;
    run_frame(40, 64'd3, "RND", lat);
    rand_rdy = 1'b0;
    st_if.i_data_ready = 1'b1;

    // fval high for 3 clk: fall remembered during leader, payload size taken at the fall.
    pay_in = 32'h0000_0111;
    i_fval = 1'b1;
    fork
      begin
        repeat (3) step();
        i_fval = 1'b0;
        repeat (6) step();
        pay_in = 32'h0000_0999;
      end
      begin
        collect_leader(64'd4, "SHORT", lat);
        collect_trailer(64'd4, 16'h0000, 32'h0000_0111, "SHORT", lat_t);
      end
    join
    chk("SHORT_trailer_gap", 64'(lat_t), 64'd0);
    pay_in = 32'h0004_B000;

    // Second rise while the trailer is stalled.
    i_fval = 1'b1;
    collect_leader(64'd5, "DROP", lat);
    st_if.i_data_ready = 1'b0;
    i_fval = 1'b0;
    repeat (5) step();
    chk("DROP_T0_pending", 64'({st_if.o_data_valid, st_if.ov_data}), 64'({1'b1, 32'h5456_3355}));
    pay_in = 32'hDEAD_BEEF;
    i_fval = 1'b1;
    cnt = 0;
    repeat (8) begin step(); cnt += int'(o_frame_drop); end
    i_fval = 1'b0;
    repeat (8) begin step(); cnt += int'(o_frame_drop); end
    chk("DROP_pulses", 64'(cnt), 64'd1);
    chk("DROP_T0_still", 64'({st_if.o_data_valid, st_if.ov_data}), 64'({1'b1, 32'h5456_3355}));
    pay_in = 32'h0004_B000;
    st_if.i_data_ready = 1'b1;
    collect_trailer(64'd5, 16'hA100, 32'h0004_B000, "DROP", lat_t);
    cnt = 0;
    repeat (30) begin step(); cnt += int'(st_if.o_data_valid); end
    chk("DROP_no_extra_words", 64'(cnt), 64'd0);
    run_frame(40, 64'd6, "POST", lat);

    // Reset while W6 is on the bus.
    i_fval = 1'b1;
    for (int i = 0; i < 6; i++) get_word(d, f, lat);
    chk("RST_W5", 64'(d), 64'(ts_v[31:0]));
    chk("RST_W6_present", 64'({st_if.o_data_valid, st_if.ov_data}), 64'({1'b1, ts_v[63:32]}));
    reset_n = 1'b0;
    i_fval  = 1'b0;
    #1;
    chk_outputs_zero("RST_async");
    repeat (3) step();
    reset_n = 1'b1;
    cnt = 0;
    repeat (20) begin step(); cnt += int'(st_if.o_data_valid); end
    chk("RST_no_partial", 64'(cnt), 64'd0);
    run_frame(40, 64'd0, "RST", lat);
    chk("RST_first_word_latency", 64'(lat), 64'd5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
